// File: rtl/tt_power_pkg.sv
// -----------------------------------------------------------------------------
// tt_power_pkg
// Shared definitions for the power-burst tile: operating mode encodings, the
// burst FSM state type, the bank operation type, the reset value of the burst
// length registers and the maximal-length LFSR tap table indexed by width.
// No ports; imported by the interface, bank and top-level files.
// -----------------------------------------------------------------------------
package tt_power_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_BURST  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } burst_state_t;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_TOGGLE = 2'd1,
        OP_LFSR   = 2'd2
    } bank_op_t;

    // Both burst length registers come out of reset at this value, giving a
    // four-cycle ON / four-cycle OFF burst without any configuration.
    localparam logic [7:0] CFG_RESET = 8'd3;

    // One-hot mask for a 1-based tap position.
    function automatic logic [63:0] tap(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Feedback tap masks for maximal-length Fibonacci LFSRs of 4..64 bits.
    // Bit (n-1) set means stage n feeds the XOR that is shifted into bit 0.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] t;
        case (width)
            4:  t = tap(4)  | tap(3);
            5:  t = tap(5)  | tap(3);
            6:  t = tap(6)  | tap(5);
            7:  t = tap(7)  | tap(6);
            8:  t = tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  t = tap(9)  | tap(5);
            10: t = tap(10) | tap(7);
            11: t = tap(11) | tap(9);
            12: t = tap(12) | tap(6)  | tap(4)  | tap(1);
            13: t = tap(13) | tap(4)  | tap(3)  | tap(1);
            14: t = tap(14) | tap(5)  | tap(3)  | tap(1);
            15: t = tap(15) | tap(14);
            16: t = tap(16) | tap(15) | tap(13) | tap(4);
            17: t = tap(17) | tap(14);
            18: t = tap(18) | tap(11);
            19: t = tap(19) | tap(6)  | tap(2)  | tap(1);
            20: t = tap(20) | tap(17);
            21: t = tap(21) | tap(19);
            22: t = tap(22) | tap(21);
            23: t = tap(23) | tap(18);
            24: t = tap(24) | tap(23) | tap(22) | tap(17);
            25: t = tap(25) | tap(22);
            26: t = tap(26) | tap(6)  | tap(2)  | tap(1);
            27: t = tap(27) | tap(5)  | tap(2)  | tap(1);
            28: t = tap(28) | tap(25);
            29: t = tap(29) | tap(27);
            30: t = tap(30) | tap(6)  | tap(4)  | tap(1);
            31: t = tap(31) | tap(28);
            32: t = tap(32) | tap(22) | tap(2)  | tap(1);
            33: t = tap(33) | tap(20);
            34: t = tap(34) | tap(27) | tap(2)  | tap(1);
            35: t = tap(35) | tap(33);
            36: t = tap(36) | tap(25);
            37: t = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
            38: t = tap(38) | tap(6)  | tap(5)  | tap(1);
            39: t = tap(39) | tap(35);
            40: t = tap(40) | tap(38) | tap(21) | tap(19);
            41: t = tap(41) | tap(38);
            42: t = tap(42) | tap(41) | tap(20) | tap(19);
            43: t = tap(43) | tap(42) | tap(38) | tap(37);
            44: t = tap(44) | tap(43) | tap(18) | tap(17);
            45: t = tap(45) | tap(44) | tap(42) | tap(41);
            46: t = tap(46) | tap(45) | tap(26) | tap(25);
            47: t = tap(47) | tap(42);
            48: t = tap(48) | tap(47) | tap(21) | tap(20);
            49: t = tap(49) | tap(40);
            50: t = tap(50) | tap(49) | tap(24) | tap(23);
            51: t = tap(51) | tap(50) | tap(36) | tap(35);
            52: t = tap(52) | tap(49);
            53: t = tap(53) | tap(52) | tap(38) | tap(37);
            54: t = tap(54) | tap(53) | tap(18) | tap(17);
            55: t = tap(55) | tap(31);
            56: t = tap(56) | tap(55) | tap(35) | tap(34);
            57: t = tap(57) | tap(50);
            58: t = tap(58) | tap(39);
            59: t = tap(59) | tap(58) | tap(38) | tap(37);
            60: t = tap(60) | tap(59);
            61: t = tap(61) | tap(60) | tap(46) | tap(45);
            62: t = tap(62) | tap(61) | tap(6)  | tap(5);
            63: t = tap(63) | tap(62);
            64: t = tap(64) | tap(63) | tap(61) | tap(60);
            default: t = tap(4) | tap(3);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tt_um_power_burst_if.sv
// -----------------------------------------------------------------------------
// tt_um_power_burst_if
// Pin bundle of the power-burst tile (everything except clk/rst_n).
//   ena     : global enable
//   ui_in   : [1:0] mode, [5:2] bank mask, [6] cfg_sel, [7] cfg_wr
//   uio_in  : configuration data byte
//   uo_out  : [3:0] bank LSBs, [5:4] FSM state, [6] active, [7] heartbeat
//   uio_out : unused output byte (always 0)
//   uio_oe  : bidirectional enables (always 0, all uio pins are inputs)
// master = whatever drives the tile pins, slave = the tile itself.
// -----------------------------------------------------------------------------
interface tt_um_power_burst_if;
    import tt_power_pkg::*;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/tt_um_power_burst_bank.sv
// -----------------------------------------------------------------------------
// power_bank
// One activity bank: a BANK_WIDTH-bit register that holds, inverts, or steps as
// a maximal-length Fibonacci LFSR, one operation per enabled clock.
//   clk, rst_n : clock, asynchronous active-low reset (register clears to 0)
//   en         : update strobe for this bank
//   op         : OP_HOLD / OP_TOGGLE / OP_LFSR
//   q          : bank register
// -----------------------------------------------------------------------------
module power_bank
    import tt_power_pkg::*;
#(
    parameter int          BANK_WIDTH = 16,
    parameter int unsigned SEED       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  bank_op_t              op,
    output logic [BANK_WIDTH-1:0] q
);

    localparam logic [63:0]           TAPS     = lfsr_taps(BANK_WIDTH);
    localparam logic [BANK_WIDTH-1:0] TAP_MASK = TAPS[BANK_WIDTH-1:0];
    localparam logic [BANK_WIDTH-1:0] SEED_VAL = BANK_WIDTH'(SEED);

    logic feedback;

    assign feedback = ^(q & TAP_MASK);

    // An all-zero register is the one state an XOR LFSR can never leave, so
    // in LFSR mode it is replaced by the bank's seed instead of being stepped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            case (op)
                OP_TOGGLE: q <= ~q;
                OP_LFSR:   q <= (q == '0) ? SEED_VAL : {q[BANK_WIDTH-2:0], feedback};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_power_burst.sv
// -----------------------------------------------------------------------------
// tt_um_power_burst
// Switching-activity generator: up to four banks of flops that hold, toggle,
// run as LFSRs, or toggle in programmable ON/OFF bursts, plus a heartbeat.
//   clk     : clock, all flops on rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : global enable, 0 freezes every register
//   ui_in   : [1:0] mode, [5:2] bank mask, [6] cfg_sel, [7] cfg_wr
//   uio_in  : config byte written to on_len (cfg_sel=0) / off_len (cfg_sel=1)
//   uo_out  : [3:0] bank LSBs, [5:4] burst state, [6] active, [7] heartbeat
//   uio_out : tied 0
//   uio_oe  : tied 0
// -----------------------------------------------------------------------------
module tt_um_power_burst
    import tt_power_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WIDTH = 16,
    parameter int HB_BIT     = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] BANK_PRESENT = 4'((1 << NUM_BANKS) - 1);

    mode_t        mode;
    logic [3:0]   eff_mask;
    logic         cfg_sel;
    logic         cfg_wr;
    logic [7:0]   on_len;
    logic [7:0]   off_len;
    burst_state_t state;
    logic [7:0]   cnt;
    logic [HB_BIT:0] hb;
    bank_op_t     bank_op;
    logic [3:0]   bank_lsb;
    logic         active;

    assign mode     = mode_t'(ui_in[1:0]);
    assign eff_mask = ui_in[5:2] & BANK_PRESENT;
    assign cfg_sel  = ui_in[6];
    assign cfg_wr   = ui_in[7];

    // Burst length registers; only the FSM reload reads them, so a write
    // during a burst never disturbs the phase already counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_len  <= CFG_RESET;
            off_len <= CFG_RESET;
        end else if (ena && cfg_wr) begin
            if (cfg_sel) begin
                off_len <= uio_in;
            end else begin
                on_len <= uio_in;
            end
        end
    end

    // Burst FSM: the counter is loaded with the phase length and the phase
    // ends on the cycle it reads zero, so each phase lasts length+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (ena) begin
            if (mode != MODE_BURST) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ON;
                        cnt   <= on_len;
                    end
                    ST_ON: begin
                        if (cnt == 8'd0) begin
                            state <= ST_OFF;
                            cnt   <= off_len;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    ST_OFF: begin
                        if (cnt == 8'd0) begin
                            state <= ST_ON;
                            cnt   <= on_len;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Free-running heartbeat, only its top bit leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb <= '0;
        end else if (ena) begin
            hb <= hb + {{HB_BIT{1'b0}}, 1'b1};
        end
    end

    // The bank operation follows the mode input directly; burst mode only
    // toggles while the FSM sits in ON.
    always_comb begin
        bank_op = OP_HOLD;
        case (mode)
            MODE_TOGGLE: bank_op = OP_TOGGLE;
            MODE_LFSR:   bank_op = OP_LFSR;
            MODE_BURST:  bank_op = (state == ST_ON) ? OP_TOGGLE : OP_HOLD;
            default:     bank_op = OP_HOLD;
        endcase
    end

    // Absent bank slots read back as 0 on their output bit.
    for (genvar i = 0; i < 4; i++) begin : g_bank
        if (i < NUM_BANKS) begin : g_present
            logic [BANK_WIDTH-1:0] q;
            logic                  unused_upper;

            power_bank #(
                .BANK_WIDTH (BANK_WIDTH),
                .SEED       (i + 1)
            ) u_bank (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (ena & eff_mask[i]),
                .op    (bank_op),
                .q     (q)
            );

            assign bank_lsb[i]  = q[0];
            assign unused_upper = ^q[BANK_WIDTH-1:1];
        end else begin : g_absent
            assign bank_lsb[i] = 1'b0;
        end
    end

    // Activity flag reflects the selected mode rather than ena, so freezing
    // the tile leaves every output bit steady; gated by rst_n so the outputs
    // read all-zero while reset is held.
    always_comb begin
        active = 1'b0;
        case (mode)
            MODE_TOGGLE, MODE_LFSR: active = (eff_mask != 4'd0);
            MODE_BURST:             active = (state == ST_ON);
            default:                active = 1'b0;
        endcase
        active = active & rst_n;
    end

    assign uo_out  = {hb[HB_BIT], active, 2'(state), bank_lsb};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_power_burst.md
TT_UM_POWER_BURST -- requirements
Module: tt_um_power_burst

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent activity banks (legal 1..4).
REQ-002 SHALL have parameter BANK_WIDTH, default 16, flops per bank (legal 4..64).
REQ-003 SHALL have parameter HB_BIT, default 23, heartbeat counter bit driven to uo_out[7].
REQ-004 SHALL have port clk, input, 1, the single clock; all flops sample on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, global enable; 0 freezes banks, FSM and heartbeat.
REQ-007 SHALL have port ui_in, input, 8: [1:0] mode, [5:2] bank enable mask, [6] cfg_sel, [7] cfg_wr.
REQ-008 SHALL have port uio_in, input, 8, configuration data byte.
REQ-009 SHALL have port uo_out, output, 8: [3:0] bank LSBs, [5:4] FSM state, [6] active, [7] heartbeat.
REQ-010 SHALL have port uio_out, output, 8, tied 0.
REQ-011 SHALL have port uio_oe, output, 8, tied 0 (all uio pins inputs).

Function
REQ-012 SHALL decode mode: 0 OFF (banks hold), 1 TOGGLE, 2 LFSR, 3 BURST.
REQ-013 SHALL, in TOGGLE, invert every bit of each enabled bank each enabled cycle.
REQ-014 SHALL, in LFSR, advance each enabled bank one step per cycle as a maximal-length Fibonacci LFSR (taps from package per BANK_WIDTH).
REQ-015 SHALL, in LFSR, load seed (bank index + 1) instead of stepping when a bank holds all-zero (lockup guard).
REQ-016 SHALL hold a bank whose mask bit is 0, or whose index >= NUM_BANKS, in every mode.
REQ-017 SHALL implement burst FSM states IDLE=0, ON=1, OFF=2, encoded on uo_out[5:4].
REQ-018 SHALL transition IDLE->ON with down-counter loaded from on_len on the first cycle mode==3.
REQ-019 SHALL in ON toggle enabled banks (as TOGGLE); when counter==0 go OFF, load off_len; else decrement.
REQ-020 SHALL in OFF hold banks; when counter==0 go ON, load on_len; else decrement.
REQ-021 SHALL give ON phase on_len+1 cycles and OFF phase off_len+1 cycles; length 0 means one cycle.
REQ-022 SHALL return to IDLE on the cycle after mode leaves 3, from any state.
REQ-023 SHALL write uio_in to on_len (cfg_sel=0) or off_len (cfg_sel=1) on every enabled cycle with cfg_wr=1.
REQ-024 SHALL apply a config write made during BURST only at the next counter reload, never to the running count.
REQ-025 SHALL drive uo_out[6]=1 while any bank is updating that cycle (TOGGLE/LFSR with nonzero effective mask, or BURST ON).
REQ-026 SHALL drive uo_out[3:0] as bit 0 of banks 0..3 (0 for absent banks), combinationally from bank registers.
REQ-027 SHALL increment a free-running HB_BIT+1-bit heartbeat counter each enabled cycle, wrapping to 0.
REQ-028 SHALL, with ena=0, hold all state including config registers, ignoring cfg_wr.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear banks, burst counter and heartbeat to 0, set FSM to IDLE, set on_len=off_len=8'd3.
REQ-030 SHALL have uo_out=8'h00 during and immediately after reset.
REQ-031 SHALL release reset synchronously to clk; first update occurs on the first rising edge with rst_n high.

Structure
REQ-032 SHALL place mode encodings, FSM state type, reset config value and per-width LFSR tap table in package tt_power_pkg.
REQ-033 SHALL implement one bank as sub-module power_bank (BANK_WIDTH, SEED; inputs en, op toggle/lfsr; output register), instantiated NUM_BANKS times by generate.

Verification
REQ-034 SHALL cover reset: rst_n low mid-BURST ON -> uo_out=0x00 asynchronously; on_len/off_len read back 3 (burst 4 on/4 off).
REQ-035 SHALL cover TOGGLE: ui_in=0x3D (mode1, mask 0xF) -> uo_out[3:0] alternates 0xF,0x0 each cycle, uo_out[6]=1.
REQ-036 SHALL cover LFSR: ui_in=0x3E from reset -> first cycle loads seeds 1,2,3,4 (uo_out[3:0]=0x5), then stepping, no bank ever all-zero over 1000 cycles.
REQ-037 SHALL cover BURST: on_len=2, off_len=0, ui_in=0x07 -> state IDLE,ON x3,OFF x1,ON x3...; bank0 LSB toggles only in ON.
REQ-038 SHALL cover mid-burst config write of on_len=5 during ON -> current ON unchanged, next ON lasts 6 cycles.
REQ-039 SHALL cover ena=0 for 10 cycles in TOGGLE -> all outputs frozen, heartbeat unchanged, cfg_wr ignored.
